// File: rtl/spi_reg_target.sv
// SPI target for 48-bit MCU register frames: synchronises the SPI pins into clk,
// decodes read/write commands and runs single transactions on the register bus.
module spi_reg_target #(
    parameter logic [31:0] RD_LATE_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic [11:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr_req,
    input  logic        reg_wr_ack,
    output logic        reg_rd_req,
    input  logic        reg_rd_ack,
    input  logic [31:0] reg_rdata,
    output logic        rd_late
);

    typedef enum logic [1:0] {FIdle, FHdr, FData, FDone} frame_e;
    typedef enum logic [1:0] {BIdle, BRd, BWr} bus_e;

    logic [1:0]  sclk_sync, ncs_sync, din_sync;
    logic        sclk_prev;
    logic        sclk_s, ncs_s, din_s, rise;

    frame_e      frame_q;
    logic [5:0]  n_q, edge_num;
    logic [46:0] rx_q;
    logic [47:0] rx_next;
    logic [31:0] tx_q;
    logic        rd_frame_q, dout_q, rd_late_q;
    logic        edge_ok, rd_evt, wr_evt, ld_evt;

    bus_e        bus_q;
    logic [11:0] addr_q, wr_pend_addr_q, rd_pend_addr_q;
    logic [31:0] wdata_q, wr_pend_data_q, rd_data_q;
    logic        wr_req_q, rd_req_q, wr_pend_q, rd_pend_q;
    logic        rd_pend_want_q, rd_want_q, rd_valid_q;
    logic        wr_avail, rd_avail, rd_want_sel, rd_ok;
    logic [11:0] wr_addr_sel, rd_addr_sel;
    logic [31:0] wr_data_sel, rd_word;
    logic        unused_pad;

    assign sclk_s = sclk_sync[1];
    assign ncs_s  = ncs_sync[1];
    assign din_s  = din_sync[1];
    // chip select high masks any edge seen in the same cycle
    assign rise   = sclk_s & ~sclk_prev & ~ncs_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            din_sync  <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            ncs_sync  <= {ncs_sync[0], spi_ncs};
            din_sync  <= {din_sync[0], spi_din};
            sclk_prev <= sclk_s;
        end
    end

    always_comb begin
        edge_ok     = rise & ((frame_q == FHdr) | (frame_q == FData));
        edge_num    = n_q + 6'd1;
        rx_next     = {rx_q, din_s};
        rd_evt      = edge_ok & (edge_num == 6'd14) & (rx_next[13:12] == 2'b00);
        wr_evt      = edge_ok & (edge_num == 6'd48) & (rx_next[47:46] == 2'b01);
        ld_evt      = edge_ok & (edge_num == 6'd16);
        wr_avail    = wr_pend_q | wr_evt;
        wr_addr_sel = wr_evt ? rx_next[45:34] : wr_pend_addr_q;
        wr_data_sel = wr_evt ? rx_next[31:0] : wr_pend_data_q;
        rd_avail    = rd_pend_q | rd_evt;
        rd_addr_sel = rd_evt ? rx_next[11:0] : rd_pend_addr_q;
        rd_want_sel = rd_evt | rd_pend_want_q;
        // an ack landing on the deadline cycle still makes it into this frame
        rd_ok       = rd_valid_q | ((bus_q == BRd) & reg_rd_ack & rd_want_q);
        rd_word     = rd_valid_q ? rd_data_q : reg_rdata;
    end

    assign unused_pad = ^rx_next[33:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q    <= FIdle;
            n_q        <= 6'd0;
            rx_q       <= '0;
            tx_q       <= '0;
            rd_frame_q <= 1'b0;
            dout_q     <= 1'b0;
            rd_late_q  <= 1'b0;
        end else begin
            rd_late_q <= 1'b0;
            dout_q    <= (frame_q == FData) & rd_frame_q & tx_q[31];
            if (ncs_s) begin
                frame_q    <= FIdle;
                n_q        <= 6'd0;
                rx_q       <= '0;
                tx_q       <= '0;
                rd_frame_q <= 1'b0;
            end else begin
                case (frame_q)
                    FIdle: frame_q <= FHdr;
                    FHdr, FData: begin
                        if (rise) begin
                            n_q  <= edge_num;
                            rx_q <= rx_next[46:0];
                            if (edge_num == 6'd14) rd_frame_q <= (rx_next[13:12] == 2'b00);
                            if (edge_num == 6'd16) begin
                                frame_q <= FData;
                                if (rd_frame_q) begin
                                    tx_q      <= rd_ok ? rd_word : RD_LATE_DATA;
                                    rd_late_q <= ~rd_ok;
                                end
                            end else if (edge_num == 6'd48) begin
                                frame_q <= FDone;
                            end else if (frame_q == FData) begin
                                tx_q <= {tx_q[30:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_q          <= BIdle;
            addr_q         <= '0;
            wdata_q        <= '0;
            wr_req_q       <= 1'b0;
            rd_req_q       <= 1'b0;
            wr_pend_q      <= 1'b0;
            wr_pend_addr_q <= '0;
            wr_pend_data_q <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_addr_q <= '0;
            rd_pend_want_q <= 1'b0;
            rd_want_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            if (rd_evt) rd_valid_q <= 1'b0;
            case (bus_q)
                BIdle: begin
                    // a queued write goes first so a following read sees its effect
                    if (wr_avail) begin
                        bus_q          <= BWr;
                        wr_req_q       <= 1'b1;
                        addr_q         <= wr_addr_sel;
                        wdata_q        <= wr_data_sel;
                        wr_pend_q      <= 1'b0;
                        rd_pend_q      <= rd_avail;
                        rd_pend_addr_q <= rd_addr_sel;
                        rd_pend_want_q <= rd_want_sel;
                    end else if (rd_avail) begin
                        bus_q     <= BRd;
                        rd_req_q  <= 1'b1;
                        addr_q    <= rd_addr_sel;
                        rd_pend_q <= 1'b0;
                        rd_want_q <= rd_want_sel;
                    end
                end
                default: begin
                    if (wr_evt) begin
                        wr_pend_q      <= 1'b1;
                        wr_pend_addr_q <= rx_next[45:34];
                        wr_pend_data_q <= rx_next[31:0];
                    end
                    if (rd_evt) begin
                        rd_pend_q      <= 1'b1;
                        rd_pend_addr_q <= rx_next[11:0];
                        rd_pend_want_q <= 1'b1;
                    end
                    if ((bus_q == BWr) && reg_wr_ack) begin
                        wr_req_q <= 1'b0;
                        bus_q    <= BIdle;
                    end
                    if ((bus_q == BRd) && reg_rd_ack) begin
                        rd_req_q <= 1'b0;
                        bus_q    <= BIdle;
                        if (rd_want_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= reg_rdata;
                        end
                    end
                end
            endcase
            // past the deadline or frame aborted: outstanding read data is discarded
            if (ld_evt | ncs_s) begin
                rd_want_q      <= 1'b0;
                rd_pend_want_q <= 1'b0;
            end
        end
    end

    assign spi_dout   = dout_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_wr_req = wr_req_q;
    assign reg_rd_req = rd_req_q;
    assign rd_late    = rd_late_q;

endmodule
